// File: rtl/riscv_pkg.sv
// Shared encodings for the hazard unit: multi-cycle FSM states,
// forward-select codes and the load result-source value.
package riscv_pkg;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/riscv_fwd_sel.sv
// Single operand forward select; the memory stage wins over writeback
// because it holds the younger result.
module riscv_fwd_sel
   import riscv_pkg::*;
(
   input  logic [4:0] rsaddr_e,
   input  logic [4:0] rdaddr_m,
   input  logic [4:0] rdaddr_w,
   input  logic       regwrite_m,
   input  logic       regwrite_w,
   output logic [1:0] fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (regwrite_w && (rdaddr_w != 5'd0) && (rdaddr_w == rsaddr_e)) begin
         fwd_sel = FWD_WB;
      end
      if (regwrite_m && (rdaddr_m != 5'd0) && (rdaddr_m == rsaddr_e)) begin
         fwd_sel = FWD_MEM;
      end
   end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use bubble, branch
// flush and the stall/abort sequencing for the multi-cycle mul/div unit.
module riscv_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned MDU_TIMEOUT = 64
) (
   input  logic       i_riscv_hzrd_clk,
   input  logic       i_riscv_hzrd_rst_n,
   input  logic [4:0] i_riscv_hzrd_rs1addr_d,
   input  logic [4:0] i_riscv_hzrd_rs2addr_d,
   input  logic [4:0] i_riscv_hzrd_rs1addr_e,
   input  logic [4:0] i_riscv_hzrd_rs2addr_e,
   input  logic [4:0] i_riscv_hzrd_rdaddr_e,
   input  logic [1:0] i_riscv_hzrd_resultsrc_e,
   input  logic [4:0] i_riscv_hzrd_rdaddr_m,
   input  logic [4:0] i_riscv_hzrd_rdaddr_w,
   input  logic       i_riscv_hzrd_regwrite_m,
   input  logic       i_riscv_hzrd_regwrite_w,
   input  logic       i_riscv_hzrd_pcsrc_e,
   input  logic       i_riscv_hzrd_mdureq_e,
   input  logic       i_riscv_hzrd_mdudone,
   output logic       o_riscv_hzrd_stall_f,
   output logic       o_riscv_hzrd_stall_d,
   output logic       o_riscv_hzrd_stall_e,
   output logic       o_riscv_hzrd_flush_d,
   output logic       o_riscv_hzrd_flush_e,
   output logic [1:0] o_riscv_hzrd_fwda_e,
   output logic [1:0] o_riscv_hzrd_fwdb_e,
   output logic       o_riscv_hzrd_mdustart,
   output logic       o_riscv_hzrd_mdutimeout,
   output logic       o_riscv_hzrd_state_dbg
);

   localparam int unsigned CNT_W = $clog2(MDU_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MDU_TIMEOUT);

   mdu_state_e       state, state_nxt;
   logic [CNT_W-1:0] busy_cnt, busy_cnt_nxt;
   logic             cnt_at_limit;
   logic             timeout_hit;
   logic             mdu_stall;
   logic             lwstall;

   riscv_fwd_sel u_fwd_a (
      .rsaddr_e   (i_riscv_hzrd_rs1addr_e),
      .rdaddr_m   (i_riscv_hzrd_rdaddr_m),
      .rdaddr_w   (i_riscv_hzrd_rdaddr_w),
      .regwrite_m (i_riscv_hzrd_regwrite_m),
      .regwrite_w (i_riscv_hzrd_regwrite_w),
      .fwd_sel    (o_riscv_hzrd_fwda_e)
   );

   riscv_fwd_sel u_fwd_b (
      .rsaddr_e   (i_riscv_hzrd_rs2addr_e),
      .rdaddr_m   (i_riscv_hzrd_rdaddr_m),
      .rdaddr_w   (i_riscv_hzrd_rdaddr_w),
      .regwrite_m (i_riscv_hzrd_regwrite_m),
      .regwrite_w (i_riscv_hzrd_regwrite_w),
      .fwd_sel    (o_riscv_hzrd_fwdb_e)
   );

   assign cnt_at_limit = (busy_cnt >= TIMEOUT_CNT);
   assign timeout_hit  = (state == MDU_BUSY) && !i_riscv_hzrd_mdudone && cnt_at_limit;

   // mdustart is a one-cycle request the unit always accepts; mdudone is a
   // one-cycle completion pulse that only has meaning while BUSY.
   always_ff @(posedge i_riscv_hzrd_clk or negedge i_riscv_hzrd_rst_n) begin
      if (!i_riscv_hzrd_rst_n) begin
         state                   <= MDU_IDLE;
         busy_cnt                <= '0;
         o_riscv_hzrd_mdutimeout <= 1'b0;
      end else begin
         state                   <= state_nxt;
         busy_cnt                <= busy_cnt_nxt;
         o_riscv_hzrd_mdutimeout <= timeout_hit;
      end
   end

   always_comb begin
      state_nxt    = state;
      busy_cnt_nxt = busy_cnt;
      case (state)
         MDU_IDLE: begin
            if (i_riscv_hzrd_mdureq_e && !i_riscv_hzrd_pcsrc_e) begin
               state_nxt    = MDU_BUSY;
               busy_cnt_nxt = '0;
            end
         end
         MDU_BUSY: begin
            if (i_riscv_hzrd_mdudone || cnt_at_limit) begin
               state_nxt = MDU_IDLE;
            end
            if (!cnt_at_limit) begin
               busy_cnt_nxt = busy_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   // Stalls drop in the done (or abort) cycle so the op leaves E on that edge.
   always_comb begin
      o_riscv_hzrd_mdustart = (state == MDU_IDLE) && i_riscv_hzrd_mdureq_e && !i_riscv_hzrd_pcsrc_e;
      mdu_stall = o_riscv_hzrd_mdustart ||
                  ((state == MDU_BUSY) && !i_riscv_hzrd_mdudone && !cnt_at_limit);
      lwstall = (i_riscv_hzrd_resultsrc_e == RESULTSRC_LOAD) &&
                (i_riscv_hzrd_rdaddr_e != 5'd0) &&
                ((i_riscv_hzrd_rdaddr_e == i_riscv_hzrd_rs1addr_d) ||
                 (i_riscv_hzrd_rdaddr_e == i_riscv_hzrd_rs2addr_d));
      o_riscv_hzrd_stall_e   = mdu_stall;
      o_riscv_hzrd_stall_f   = mdu_stall || (lwstall && !i_riscv_hzrd_pcsrc_e);
      o_riscv_hzrd_stall_d   = mdu_stall || (lwstall && !i_riscv_hzrd_pcsrc_e);
      o_riscv_hzrd_flush_d   = i_riscv_hzrd_pcsrc_e;
      o_riscv_hzrd_flush_e   = i_riscv_hzrd_pcsrc_e || (lwstall && !mdu_stall);
      o_riscv_hzrd_state_dbg = (state == MDU_BUSY);
   end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: two instances (default and short timeout)
// checked every cycle against a cycle-count reference model.
module tb_riscv_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic [1:0] rsrc;
   logic       regwm, regww, pcsrc, req, done;

   logic [1:0] stall_f, stall_d, stall_e, flush_d, flush_e, start, tmo_o, st_dbg;
   logic [1:0] fwda [2];
   logic [1:0] fwdb [2];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model: age = cycles spent busy so far, -1 when idle
   int       lim [2] = '{64, 4};
   int       age [2] = '{-1, -1};
   bit       exp_to [2] = '{1'b0, 1'b0};
   int       age_n [2];
   bit       to_n [2];
   logic [7:0] obs_ctrl [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   riscv_hazard_ctrl u_dut64 (
      .i_riscv_hzrd_clk(clk), .i_riscv_hzrd_rst_n(rst_n),
      .i_riscv_hzrd_rs1addr_d(rs1d), .i_riscv_hzrd_rs2addr_d(rs2d),
      .i_riscv_hzrd_rs1addr_e(rs1e), .i_riscv_hzrd_rs2addr_e(rs2e),
      .i_riscv_hzrd_rdaddr_e(rde), .i_riscv_hzrd_resultsrc_e(rsrc),
      .i_riscv_hzrd_rdaddr_m(rdm), .i_riscv_hzrd_rdaddr_w(rdw),
      .i_riscv_hzrd_regwrite_m(regwm), .i_riscv_hzrd_regwrite_w(regww),
      .i_riscv_hzrd_pcsrc_e(pcsrc), .i_riscv_hzrd_mdureq_e(req),
      .i_riscv_hzrd_mdudone(done),
      .o_riscv_hzrd_stall_f(stall_f[0]), .o_riscv_hzrd_stall_d(stall_d[0]),
      .o_riscv_hzrd_stall_e(stall_e[0]), .o_riscv_hzrd_flush_d(flush_d[0]),
      .o_riscv_hzrd_flush_e(flush_e[0]), .o_riscv_hzrd_fwda_e(fwda[0]),
      .o_riscv_hzrd_fwdb_e(fwdb[0]), .o_riscv_hzrd_mdustart(start[0]),
      .o_riscv_hzrd_mdutimeout(tmo_o[0]), .o_riscv_hzrd_state_dbg(st_dbg[0])
   );

   riscv_hazard_ctrl #(.MDU_TIMEOUT(4)) u_dut4 (
      .i_riscv_hzrd_clk(clk), .i_riscv_hzrd_rst_n(rst_n),
      .i_riscv_hzrd_rs1addr_d(rs1d), .i_riscv_hzrd_rs2addr_d(rs2d),
      .i_riscv_hzrd_rs1addr_e(rs1e), .i_riscv_hzrd_rs2addr_e(rs2e),
      .i_riscv_hzrd_rdaddr_e(rde), .i_riscv_hzrd_resultsrc_e(rsrc),
      .i_riscv_hzrd_rdaddr_m(rdm), .i_riscv_hzrd_rdaddr_w(rdw),
      .i_riscv_hzrd_regwrite_m(regwm), .i_riscv_hzrd_regwrite_w(regww),
      .i_riscv_hzrd_pcsrc_e(pcsrc), .i_riscv_hzrd_mdureq_e(req),
      .i_riscv_hzrd_mdudone(done),
      .o_riscv_hzrd_stall_f(stall_f[1]), .o_riscv_hzrd_stall_d(stall_d[1]),
      .o_riscv_hzrd_stall_e(stall_e[1]), .o_riscv_hzrd_flush_d(flush_d[1]),
      .o_riscv_hzrd_flush_e(flush_e[1]), .o_riscv_hzrd_fwda_e(fwda[1]),
      .o_riscv_hzrd_fwdb_e(fwdb[1]), .o_riscv_hzrd_mdustart(start[1]),
      .o_riscv_hzrd_mdutimeout(tmo_o[1]), .o_riscv_hzrd_state_dbg(st_dbg[1])
   );

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (regwm && rdm != 5'd0 && rdm == rs) return 2'b10;
      if (regww && rdw != 5'd0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   // ctrl vector: stall_f stall_d stall_e flush_d flush_e start timeout busy
   task automatic check_all(input string tag);
      bit idle, st, mst, lw;
      logic [7:0] exp_ctrl;
      lw = (rsrc == 2'b01) && (rde != 5'd0) && (rde == rs1d || rde == rs2d);
      for (int k = 0; k < 2; k++) begin
         idle = (age[k] < 0);
         st   = idle && req && !pcsrc && rst_n;
         mst  = st || (!idle && !done && age[k] < lim[k]);
         exp_ctrl = {mst || (lw && !pcsrc), mst || (lw && !pcsrc), mst, pcsrc,
                     pcsrc || (lw && !mst), st, exp_to[k], !idle};
         obs_ctrl[k] = {stall_f[k], stall_d[k], stall_e[k], flush_d[k], flush_e[k],
                        start[k], tmo_o[k], st_dbg[k]};
         cmp($sformatf("%s_ctrl%0d", tag, k), {8'h0, obs_ctrl[k]}, {8'h0, exp_ctrl});
         cmp($sformatf("%s_fwd%0d", tag, k), {12'h0, fwda[k], fwdb[k]},
             {12'h0, fwd_ref(rs1e), fwd_ref(rs2e)});
         if (!rst_n) begin
            age_n[k] = -1; to_n[k] = 1'b0;
         end else if (idle) begin
            age_n[k] = st ? 0 : -1; to_n[k] = 1'b0;
         end else if (done) begin
            age_n[k] = -1; to_n[k] = 1'b0;
         end else if (age[k] >= lim[k]) begin
            age_n[k] = -1; to_n[k] = 1'b1;
         end else begin
            age_n[k] = age[k] + 1; to_n[k] = 1'b0;
         end
      end
   endtask

   task automatic tick(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         age[k] = age_n[k];
         exp_to[k] = to_n[k];
      end
   endtask

   task automatic clear_inputs();
      {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
      rsrc = 2'b00; regwm = 1'b0; regww = 1'b0;
      pcsrc = 1'b0; req = 1'b0; done = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      clear_inputs();
      #2;
      for (int k = 0; k < 2; k++) begin
         cmp($sformatf("reset_all_zero%0d", k),
             {5'h0, stall_f[k], stall_d[k], stall_e[k], flush_d[k], flush_e[k],
              fwda[k], fwdb[k], start[k], tmo_o[k], st_dbg[k]}, 16'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick("idle");

      // forwarding: memory beats writeback, r0 never forwards
      rs1e = 5'd5; rdm = 5'd5; regwm = 1'b1; rdw = 5'd5; regww = 1'b1;
      tick("fwd_mem");
      cmp("fwda_mem", {14'h0, fwda[0]}, 16'h2);
      rdm = 5'd0;
      tick("fwd_wb");
      rs2e = 5'd9; rdw = 5'd9; rdm = 5'd9;
      tick("fwdb_mem");
      regwm = 1'b0;
      tick("fwdb_wb");

      // load-use bubble and its suppression by r0 and by a taken branch
      clear_inputs();
      rsrc = 2'b01; rde = 5'd7; rs2d = 5'd7;
      tick("lw_stall");
      cmp("lw_stall_bits", {8'h0, obs_ctrl[0]}, 16'b1100_1000);
      rde = 5'd0; rs2d = 5'd0;
      tick("lw_r0");
      cmp("lw_r0_bits", {8'h0, obs_ctrl[0]}, 16'h0);
      rde = 5'd3; rs1d = 5'd3; pcsrc = 1'b1;
      tick("lw_branch");
      cmp("lw_branch_bits", {8'h0, obs_ctrl[0]}, 16'b0001_1000);

      // abort path on the short instance; long one stays busy, then reset
      clear_inputs();
      req = 1'b1;
      tick("to_start");
      req = 1'b0;
      cnt = (obs_ctrl[1][7]) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         tick("to_busy");
         if (obs_ctrl[1][7]) cnt++;
      end
      cmp("to_stall_cycles", 16'(cnt), 16'd5);
      tick("to_pulse");
      cmp("to_pulse_bit", {15'h0, obs_ctrl[1][1]}, 16'h1);
      tick("to_after");
      rst_n = 1'b0;
      #1;
      cmp("rst_mid_busy", {13'h0, stall_f[0], st_dbg[0], tmo_o[0]}, 16'h0);
      for (int k = 0; k < 2; k++) begin
         age[k] = -1; exp_to[k] = 1'b0;
      end
      tick("in_reset");
      rst_n = 1'b1;
      tick("post_reset");

      // completion after ten busy cycles, op held in E until done
      req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 11; i++) begin
         tick("mdu_busy");
         if (obs_ctrl[0][7]) cnt++;
      end
      cmp("mdu_stall_cycles", 16'(cnt), 16'd11);
      done = 1'b1;
      tick("mdu_done");
      cmp("mdu_done_bits", {8'h0, obs_ctrl[0]}, 16'h01);
      req = 1'b0; done = 1'b0;
      tick("mdu_idle");
      cmp("mdu_idle_bits", {8'h0, obs_ctrl[0]}, 16'h0);
      done = 1'b1;
      tick("done_in_idle");
      done = 1'b0;

      // randomized traffic with small register indices to force collisions
      for (int i = 0; i < 400; i++) begin
         rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
         rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
         rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
         rdw  = 5'($urandom_range(0, 3));
         rsrc = 2'($urandom_range(0, 3));
         regwm = 1'($urandom_range(0, 1)); regww = 1'($urandom_range(0, 1));
         pcsrc = ($urandom_range(0, 7) == 0);
         req   = ($urandom_range(0, 2) == 0);
         done  = ($urandom_range(0, 9) == 0);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
